// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-memory boot loader:
// default sizes and the loader state encoding.
package mips_pkg;

    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned DEPTH          = 128;
    localparam int unsigned BYTES_PER_WORD = INSTR_WIDTH / 8;
    localparam int unsigned ST_W           = 3;

    localparam logic [ST_W-1:0] ST_HDR  = 3'd0;
    localparam logic [ST_W-1:0] ST_DATA = 3'd1;
    localparam logic [ST_W-1:0] ST_CSUM = 3'd2;
    localparam logic [ST_W-1:0] ST_RUN  = 3'd3;
    localparam logic [ST_W-1:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/byte_assembler.sv
// Packs an accepted byte stream into big-endian words; word_valid_c
// flags the edge that takes the last byte of a word, with word_c complete.
module byte_assembler
    import mips_pkg::*;
#(
    parameter int unsigned W = INSTR_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         byte_en,
    input  logic [7:0]   in_data,
    output logic [W-1:0] word_c,
    output logic         word_valid_c
);

    localparam int unsigned BPW   = W / 8;
    localparam int unsigned CNT_W = $clog2(BPW);

    logic [W-9:0]     asm_q;
    logic [CNT_W-1:0] bcnt;

    // The incoming byte lands in the low lane; earlier bytes are already shifted up.
    assign word_c       = {asm_q, in_data};
    assign word_valid_c = byte_en && (bcnt == CNT_W'(BPW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q <= '0;
            bcnt  <= '0;
        end else if (byte_en) begin
            asm_q <= word_c[W-9:0];
            bcnt  <= bcnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed program into instruction memory, then releases
// the core. Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum word.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = mips_pkg::INSTR_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = mips_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    logic [ST_W-1:0]        state, state_nxt;
    logic [IDX_W-1:0]       count, count_nxt;
    logic [IDX_W-1:0]       index, index_nxt;
    logic                   we_nxt;
    logic [ADDR_WIDTH-1:0]  addr_nxt;
    logic [INSTR_WIDTH-1:0] wdata_nxt;
    logic                   in_ready_nxt, done_nxt, error_nxt, cpu_reset_nxt;
    logic                   accept;
    logic [INSTR_WIDTH-1:0] word_c;
    logic                   word_valid_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] sum, sum_nxt;
`endif

    assign accept = in_valid && in_ready;

    byte_assembler #(.W(INSTR_WIDTH)) u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_en      (accept),
        .in_data      (in_data),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Next-state, write port and status flags.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        index_nxt = index;
        we_nxt    = 1'b0;
        addr_nxt  = imem_addr;
        wdata_nxt = imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_nxt   = sum;
`endif
        case (state)
            ST_HDR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_nxt = '0;
`endif
                if (word_valid_c) begin
                    if (word_c > INSTR_WIDTH'(DEPTH)) begin
                        state_nxt = ST_ERR;
                    end else if (word_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_RUN;
`endif
                    end else begin
                        state_nxt = ST_DATA;
                        count_nxt = IDX_W'(word_c);
                        index_nxt = '0;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid_c) begin
                    we_nxt    = 1'b1;
                    wdata_nxt = word_c;
                    addr_nxt  = ADDR_WIDTH'({index, 2'b00});
                    index_nxt = index + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_nxt   = sum + word_c;
`endif
                    if (index == count - IDX_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        state_nxt = ST_RUN;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (word_valid_c) begin
                    state_nxt = (word_c == sum) ? ST_RUN : ST_ERR;
                end
            end
`endif
            ST_RUN, ST_ERR: ;
            default: state_nxt = ST_ERR;
        endcase

        // Flags are registered copies of the next-state decode.
        in_ready_nxt  = (state_nxt == ST_HDR) || (state_nxt == ST_DATA) || (state_nxt == ST_CSUM);
        done_nxt      = (state_nxt == ST_RUN);
        error_nxt     = (state_nxt == ST_ERR);
        cpu_reset_nxt = (state_nxt != ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HDR;
            count      <= '0;
            index      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_reset  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            index      <= index_nxt;
            imem_we    <= we_nxt;
            imem_addr  <= addr_nxt;
            imem_wdata <= wdata_nxt;
            in_ready   <= in_ready_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            cpu_reset  <= cpu_reset_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= sum_nxt;
`endif
        end
    end

endmodule
